adder_share_arb: RTL and testbench
==================================

Name: adder_share_arb

Overview:
- Round-robin arbiter and sequencer that time-shares one external WIDTH-bit `full_adder` instance among NREQ requesters.
- Each requester issues add operations over a valid/ready handshake. Multi-beat (wide) additions are chained by holding the grant and feeding the registered carry-out back as the next beat's carry-in.
- Results return on a single shared response channel tagged with the requester id.
- Sits between the coefficient-processing clients and the shared adder datapath.

Parameters:
- WIDTH, `W_COE (8): operand/sum width of the shared adder.
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*WIDTH  operand A; requester k at bits [k*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- req_cin  in  NREQ  carry-in; used on first beat only.
- req_last  in  NREQ  1 = final beat; 0 = more beats follow (chain, grant locked).
- add_a  out  WIDTH  registered operand to shared adder A.
- add_b  out  WIDTH  registered operand to shared adder B.
- add_cin  out  1  registered carry to shared adder Cin.
- add_sum  in  WIDTH  shared adder Sum (combinational from add_*).
- add_cout  in  1  shared adder Cout.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  requester id of response.
- rsp_sum  out  WIDTH  captured sum.
- rsp_cout  out  1  captured carry-out.
- rsp_last  out  1  copy of the beat's req_last.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rr_ptr=0, lock=0, carry_q=0.
  - req_ready=0, add_a=0, add_b=0, add_cin=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_last=0, busy=0.
  - A reset mid-operation drops any in-flight beat and any chain lock; no response is issued.
- States: IDLE, CALC, RESP, CHAIN.
- IDLE:
  - grant g = first k with req_valid[k], searching from rr_ptr upward with wrap at NREQ.
  - req_ready[g]=1 combinationally in the same cycle; the accept occurs this cycle.
  - Latches add_a/add_b from slice g, add_cin=req_cin[g], cur_id=g, cur_last=req_last[g]. Next state CALC.
  - With no valid request: stay in IDLE, all add_* hold.
- CALC (exactly 1 cycle):
  - rsp_sum<=add_sum, rsp_cout<=add_cout, carry_q<=add_cout, rsp_id<=cur_id, rsp_last<=cur_last.
  - rsp_valid<=1. Next state RESP.
- RESP:
  - rsp_valid held, and all rsp_* held stable, until rsp_ready=1.
  - On handshake: rsp_valid<=0.
  - If cur_last=0: lock=1, next state CHAIN.
  - Otherwise: lock=0, rr_ptr<=(cur_id+1) mod NREQ, next state IDLE.
- CHAIN:
  - Only requester cur_id is eligible; req_ready[cur_id]=req_valid[cur_id]. Other requesters are ignored even if valid.
  - On accept: add_a/add_b from slice cur_id, add_cin=carry_q (req_cin ignored), cur_last updated. Next state CALC.
  - If the locked requester never re-asserts valid, the block waits in CHAIN indefinitely; no timeout.
- Latency: accept at cycle T gives rsp_valid at T+2. Maximum throughput is one beat per 3 cycles; rsp_ready held high the whole time allows a new accept at T+3.
- Arithmetic: plain WIDTH-bit add with wrap; overflow is reported only via rsp_cout. A chained N-beat operation yields an N*WIDTH-bit sum, LS word first.
- Fairness: rr_ptr advances only at the end of an operation (last beat), never per chain beat.
- req_ready is never asserted in CALC or RESP. Requests presented in those states wait with no loss.
- Simultaneous valids: only the round-robin winner is accepted; the others stay pending.
- busy=1 in CALC, RESP and CHAIN.

Test Plan:
- Single op:
  - Stimulus: req0 valid, a=8'h3C, b=8'h0F, cin=1, last=1, rsp_ready=1.
  - Required: req_ready[0] in the accept cycle; 2 cycles later rsp_valid with rsp_id=0, rsp_sum=8'h4C, rsp_cout=0, rsp_last=1.
- Round-robin:
  - Stimulus: all 4 requesters continuously valid, last=1.
  - Required: grant order 0,1,2,3,0; each op spaced 3 cycles apart.
- Chain:
  - Stimulus: req2 issues a=8'hFF,b=8'h01,cin=0,last=0, then a=8'h00,b=8'h00,last=1, while req1 is also valid.
  - Required: beat1 sum=8'h00 cout=1; beat2 sum=8'h01 cout=0 (carry applied); req1 is not granted until after beat2; rr_ptr then = 3.
- Backpressure:
  - Stimulus: rsp_ready held low 5 cycles after rsp_valid.
  - Required: rsp_* stable for those cycles; no req_ready asserted; completion on the ready cycle.
- Overflow:
  - Stimulus: a=8'h80, b=8'h80, cin=1.
  - Required: sum=8'h01, cout=1.
- Reset mid-chain:
  - Stimulus: assert rst asynchronously during RESP of a last=0 beat.
  - Required: all outputs immediately 0, state IDLE; the next grant starts from req0 with its own cin.

Source files
------------

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin time-sharing of one external adder among NREQ requesters,
// chaining multi-beat adds by locking the grant and feeding back the registered carry.
module adder_share_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ-1:0]       req_last,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_last,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP, CHAIN} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, cur_id, gnt, off, sel;
  logic [NREQ-1:0] rot;
  logic [IDW:0] sum_id;
  logic lock, carry_q, cur_last;
  // rotate valids so bit 0 is rr_ptr, take the lowest set bit, then rotate back
  always_comb begin
    rot = NREQ'({req_valid, req_valid} >> rr_ptr);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? IDW'(i) : off;
    sum_id = {1'b0, rr_ptr} + {1'b0, off};
    gnt = sum_id >= (IDW+1)'(NREQ) ? IDW'(sum_id - (IDW+1)'(NREQ)) : sum_id[IDW-1:0];
  end
  assign sel = state == CHAIN ? cur_id : gnt;
  assign req_ready = rst ? '0
                   : (state == IDLE && |req_valid) ? NREQ'(1) << gnt
                   : (state == CHAIN && lock && req_valid[cur_id]) ? NREQ'(1) << cur_id
                   : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      lock <= 1'b0;
      carry_q <= 1'b0;
      cur_id <= '0;
      cur_last <= 1'b0;
      add_a <= '0;
      add_b <= '0;
      add_cin <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
      rsp_last <= 1'b0;
    end else
      case (state)
        IDLE, CHAIN:
          if (|req_ready) begin
            add_a <= req_a[sel*WIDTH +: WIDTH];
            add_b <= req_b[sel*WIDTH +: WIDTH];
            add_cin <= state == CHAIN ? carry_q : req_cin[sel];
            cur_id <= sel;
            cur_last <= req_last[sel];
            state <= CALC;
          end
        CALC: begin
          rsp_sum <= add_sum;
          rsp_cout <= add_cout;
          carry_q <= add_cout;
          rsp_id <= cur_id;
          rsp_last <= cur_last;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            lock <= !cur_last;
            rr_ptr <= !cur_last ? rr_ptr : cur_id == IDW'(NREQ - 1) ? '0 : cur_id + 1'b1;
            state <= cur_last ? IDLE : CHAIN;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: randomized and directed scoreboard bench for adder_share_arb
module tb_adder_share_arb;
  localparam int W = 8, N = 4, IW = 2;
  typedef struct packed {logic [W-1:0] a; logic [W-1:0] b; logic cin; logic last;} beat_t;
  typedef struct packed {logic [IW-1:0] id; logic [W-1:0] sum; logic cout; logic last;} rsp_t;
  typedef struct packed {rsp_t r; logic [31:0] cyc;} sb_t;

  logic clk, rst;
  logic [N-1:0] req_valid, req_ready, req_cin, req_last;
  logic [N*W-1:0] req_a, req_b;
  logic [W-1:0] add_a, add_b, add_sum, rsp_sum;
  logic add_cin, add_cout, rsp_valid, rsp_ready, rsp_cout, rsp_last, busy;
  logic [IW-1:0] rsp_id;

  adder_share_arb #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_last(req_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_last(rsp_last), .busy(busy)
  );

  // the shared external full adder
  assign {add_cout, add_sum} = (W+1)'(add_a) + (W+1)'(add_b) + (W+1)'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t bq[N][$];
  rsp_t exp_q[$];
  sb_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [N-1:0] in_chain;
  bit mon_en = 1'b1;
  logic pv, pr;
  logic [W+IW+2:0] pvec;
  sb_t s;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic beat_t mk(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic last);
    return beat_t'{a, b, cin, last};
  endfunction

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (bq[k].size() > 0) return 1'b1;
    return exp_q.size() > 0 || sb.size() > 0;
  endfunction

  // reference: whole operations served in round-robin order, each as one wide add
  task automatic build_model();
    beat_t c[N][$];
    beat_t bt;
    rsp_t r;
    logic [63:0] av, bv, m, t;
    logic cin0;
    int ptr, k, n;
    ptr = 0;
    for (int i = 0; i < N; i++) c[i] = bq[i];
    exp_q.delete();
    forever begin
      k = -1;
      for (int i = 0; i < N; i++) if (k < 0 && c[(ptr + i) % N].size() > 0) k = (ptr + i) % N;
      if (k < 0) break;
      av = 0; bv = 0; n = 0; cin0 = c[k][0].cin;
      do begin
        bt = c[k].pop_front();
        av |= 64'(bt.a) << (W * n);
        bv |= 64'(bt.b) << (W * n);
        n++;
      end while (!bt.last);
      for (int i = 0; i < n; i++) begin
        m = (64'd1 << (W * (i + 1))) - 64'd1;
        t = (av & m) + (bv & m) + 64'(cin0);
        r.id = IW'(k); r.sum = t[W*i +: W]; r.cout = t[W*(i+1)]; r.last = (i == n - 1);
        exp_q.push_back(r);
      end
      ptr = (k + 1) % N;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; in_chain = '0;
    req_a = '0; req_b = '0; req_cin = '0; req_last = '0;
    sb.delete(); exp_q.delete();
    for (int k = 0; k < N; k++) bq[k].delete();
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'({req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum,
          rsp_cout, rsp_last, busy}), 64'd0);
    rst = 1'b0;
  endtask

  // md: 0 ready always, 1 random ready, 2 ready low for 5 cycles of each response
  task automatic run_phase(int md, bit drop, bit space);
    int budget = 0, last_acc = -1, vcnt = 0;
    rsp_t r;
    build_model();
    while (pending()) begin
      if (budget++ > 3000) begin check("phase_timeout", 1, 0); break; end
      @(negedge clk);
      vcnt = rsp_valid ? vcnt + 1 : 0;
      for (int k = 0; k < N; k++) begin
        req_valid[k] = bq[k].size() > 0 && !(drop && in_chain[k] && $urandom_range(0, 2) == 0);
        req_a[k*W +: W] = bq[k].size() > 0 ? bq[k][0].a : W'($urandom);
        req_b[k*W +: W] = bq[k].size() > 0 ? bq[k][0].b : W'($urandom);
        req_cin[k] = bq[k].size() > 0 ? bq[k][0].cin : 1'($urandom);
        req_last[k] = bq[k].size() > 0 ? bq[k][0].last : 1'($urandom);
      end
      rsp_ready = md == 0 ? 1'b1 : md == 1 ? $urandom_range(0, 2) != 0 : vcnt >= 6;
      #4;
      for (int k = 0; k < N; k++)
        if (req_valid[k] && req_ready[k]) begin
          if (exp_q.size() == 0) check("grant_extra", 64'(k), 64'hff);
          else begin
            r = exp_q.pop_front();
            check("grant_id", 64'(k), 64'(r.id));
            sb.push_back(sb_t'{r, 32'(cyc)});
          end
          in_chain[k] = !bq[k][0].last;
          void'(bq[k].pop_front());
          if (space && last_acc >= 0) check("rr_spacing", 64'(cyc - last_acc), 64'd3);
          last_acc = cyc;
        end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  // monitor: protocol checks every cycle, scoreboard compare on each response handshake
  initial forever begin
    @(negedge clk);
    #4;
    if (!mon_en || rst) pv = 1'b0;
    else begin
      check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      if (rsp_valid) begin
        check("ready_in_resp", 64'(req_ready), 64'd0);
        check("busy_in_resp", 64'(busy), 64'd1);
      end
      if (rsp_valid && !pv) begin
        if (sb.size() == 0) check("rsp_unexpected", 1, 0);
        else check("latency", 64'(cyc), 64'(sb[0].cyc + 2));
      end
      if (pv && !pr)
        check("rsp_stable", 64'({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last}), 64'(pvec));
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        s = sb.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(s.r.id));
        check("rsp_sum", 64'(rsp_sum), 64'(s.r.sum));
        check("rsp_cout", 64'(rsp_cout), 64'(s.r.cout));
        check("rsp_last", 64'(rsp_last), 64'(s.r.last));
      end
      pv = rsp_valid; pr = rsp_ready;
      pvec = {rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last};
    end
  end

  initial begin
    int nb;
    do_reset();
    bq[0].push_back(mk(8'h3C, 8'h0F, 1'b1, 1'b1));
    bq[1].push_back(mk(8'h80, 8'h80, 1'b1, 1'b1));
    run_phase(0, 1'b0, 1'b0);

    do_reset();
    for (int k = 0; k < N; k++) repeat (2) bq[k].push_back(mk(W'($urandom), W'($urandom), 1'($urandom), 1'b1));
    run_phase(0, 1'b0, 1'b1);

    do_reset();
    bq[0].push_back(mk(8'h11, 8'h22, 1'b0, 1'b1));
    bq[1].push_back(mk(8'h33, 8'h44, 1'b1, 1'b1));
    bq[1].push_back(mk(8'h55, 8'h66, 1'b0, 1'b1));
    bq[2].push_back(mk(8'hFF, 8'h01, 1'b0, 1'b0));
    bq[2].push_back(mk(8'h00, 8'h00, 1'b1, 1'b1));
    bq[3].push_back(mk(8'h77, 8'h88, 1'b0, 1'b1));
    run_phase(0, 1'b0, 1'b0);

    do_reset();
    bq[1].push_back(mk(8'hA5, 8'h5A, 1'b0, 1'b1));
    bq[3].push_back(mk(8'hF0, 8'h0F, 1'b1, 1'b1));
    run_phase(2, 1'b0, 1'b0);

    repeat (3) begin
      do_reset();
      for (int k = 0; k < N; k++)
        repeat ($urandom_range(1, 3)) begin
          nb = $urandom_range(1, 3);
          for (int i = 0; i < nb; i++)
            bq[k].push_back(mk(W'($urandom), W'($urandom), 1'($urandom), i == nb - 1));
        end
      run_phase(1, 1'b1, 1'b0);
    end

    // asynchronous reset while a chain beat waits in RESP
    do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    req_valid = 4'b0100;
    req_a[2*W +: W] = 8'hFF; req_b[2*W +: W] = 8'h01; req_cin[2] = 1'b0; req_last[2] = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    check("midchain_rsp_valid", 64'(rsp_valid), 64'd1);
    #2 rst = 1'b1;
    #1 check("async_reset", 64'({req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum,
             rsp_cout, rsp_last, busy}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0101;
    req_a[0 +: W] = 8'h01; req_b[0 +: W] = 8'h02; req_cin[0] = 1'b0; req_last[0] = 1'b1;
    #4 check("post_reset_grant", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    check("post_reset_rsp", 64'({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last}),
          64'({1'b1, 2'd0, 8'h03, 1'b0, 1'b1}));
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
